// File: rtl/gpu_core_param_pkg.sv
// Shared definitions for the parametrised SIMT core: opcodes, FSM states, instruction fields.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package gpu_core_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_CMPGE = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_LD    = 4'd11;
  localparam logic [3:0] OP_LI    = 4'd12;
  localparam logic [3:0] OP_ST    = 4'd13;
  localparam logic [3:0] OP_BNZ   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // Instruction word layout: op | ra | rb | rd
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 8;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DEC, ST_EXEC, ST_MEM, ST_MEMW, ST_WB
  } state_t;

  // Ops 1..12 always write rd; NOP writes rd only in its core-id form (IR[11]=1).
  function automatic logic writes_rd(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[OP_HI:OP_LO];
    return ((op >= OP_ADD) && (op <= OP_LI)) || ((op == OP_NOP) && ir[RA_HI]);
  endfunction

endpackage

// File: rtl/gpu_core_param_if.sv
// Shared-memory request/acknowledge bus between a core (master) and the memory (slave).
// Latency: set by the slave; the master holds a request until mem_ack is seen.
// Backpressure: the slave stalls the master simply by delaying mem_ack.
interface gpu_core_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/gpu_core_param_alu.sv
// Combinational ALU for the SIMT core: op, a, b -> result plus divide-by-zero flag.
// Latency: 0 cycles (purely combinational, registered by the caller in EXEC).
// Backpressure: none.
module gpu_core_alu
  import gpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_div0
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] w_sh;

  // Shift amount is b modulo DATA_W; DATA_W is a power of two so the low bits suffice.
  assign w_sh = i_b[SH_W-1:0];

  // Result select; results are truncated to DATA_W, divide by zero yields all-ones.
  always_comb begin
    o_result = '0;
    o_div0   = 1'b0;
    case (i_op)
      OP_ADD:   o_result = i_a + i_b;
      OP_SUB:   o_result = i_a - i_b;
      OP_MUL:   o_result = i_a * i_b;
      OP_DIV: begin
        if (i_b == '0) begin
          o_result = '1;
          o_div0   = 1'b1;
        end else begin
          o_result = i_a / i_b;
        end
      end
      OP_CMPGE: o_result = {{(DATA_W-1){1'b0}}, (i_a >= i_b)};
      OP_SHR:   o_result = i_a >> w_sh;
      OP_SHL:   o_result = i_a << w_sh;
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      default:  o_result = '0;
    endcase
  end
endmodule

// File: rtl/gpu_core_param.sv
// Multicycle SIMT core: program load into local IMEM, masked launch, FETCH/DEC/EXEC/MEM/WB.
// Latency: 5 cycles per ALU/branch/NOP/HALT, 5 + MEMW wait cycles per load/store.
// Backpressure: program words only taken while idle; memory accesses stall in MEMW until mem_ack.
module gpu_core_param
  import gpu_core_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int CORE_ID_W  = 4,
  parameter int NCORES     = 16,
  parameter int ADDR_W     = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CORE_ID_W-1:0] core_id,
  input  logic                 prog_valid,
  input  logic [15:0]          prog_data,
  input  logic                 prog_last,
  output logic                 prog_ready,
  input  logic                 launch_valid,
  input  logic [NCORES-1:0]    launch_mask,
  input  logic [DATA_W-1:0]    launch_r0,
  input  logic                 kill,
  gpu_core_param_if.master     mem,
  output logic                 ready,
  output logic                 busy,
  output logic                 err
);
  localparam int              PC_W   = $clog2(IMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(IMEM_DEPTH - 1);

  state_t             r_state, w_next;
  logic [PC_W-1:0]    r_pc, r_wr_ptr, r_last_pc;
  logic               r_loaded;
  logic [15:0]        r_imem [IMEM_DEPTH];
  logic [15:0]        r_ir;
  logic [DATA_W-1:0]  r_rf [16];
  logic [DATA_W-1:0]  r_a, r_b, r_d, r_res;
  logic               r_taken, r_err, r_ready, r_busy, r_prog_ready;
  logic               r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic [3:0]         w_op, w_ra, w_rb, w_rd;
  logic               w_launch, w_kill, w_is_mem, w_wb_end, w_div0;
  logic [DATA_W-1:0]  w_alu_res;
  logic [ADDR_W-1:0]  w_addr;

  assign w_op     = r_ir[OP_HI:OP_LO];
  assign w_ra     = r_ir[RA_HI:RA_LO];
  assign w_rb     = r_ir[RB_HI:RB_LO];
  assign w_rd     = r_ir[RD_HI:RD_LO];
  // A program word in the same cycle wins over a launch.
  assign w_launch = launch_valid && launch_mask[core_id] && r_loaded && !prog_valid;
  assign w_kill   = kill && (r_state != ST_IDLE);
  assign w_is_mem = (w_op == OP_LD) || (w_op == OP_ST);
  // Program ends on HALT or on running past the last loaded word, unless a branch is taken.
  assign w_wb_end = !r_taken && ((w_op == OP_HALT) || (r_pc == r_last_pc));
  assign w_addr   = ADDR_W'({r_a, r_b});

  assign prog_ready    = r_prog_ready;
  assign ready         = r_ready;
  assign busy          = r_busy;
  assign err           = r_err;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  gpu_core_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_res),
    .o_div0   (w_div0)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; kill overrides everything outside IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_launch) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_DEC;
      ST_DEC:   w_next = ST_EXEC;
      ST_EXEC:  w_next = ST_MEM;
      ST_MEM:   w_next = w_is_mem ? ST_MEMW : ST_WB;
      ST_MEMW:  if (mem.mem_ack) w_next = ST_WB;
      ST_WB:    w_next = w_wb_end ? ST_IDLE : ST_FETCH;
      default:  w_next = ST_IDLE;
    endcase
    if (w_kill) w_next = ST_IDLE;
  end

  // Instruction memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && prog_valid) r_imem[r_wr_ptr] <= prog_data;
  end

  // Datapath, program loader, status flags and memory request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
      r_pc         <= '0;
      r_wr_ptr     <= '0;
      r_last_pc    <= PC_MAX;
      r_loaded     <= 1'b0;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_d          <= '0;
      r_res        <= '0;
      r_taken      <= 1'b0;
      r_err        <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_prog_ready <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else if (w_kill) begin
      // Abort: drop the bus request and return idle; the pending WB never happens.
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_prog_ready <= 1'b1;
      r_pc         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (prog_valid) begin
            if (prog_last || (r_wr_ptr == PC_MAX)) begin
              r_last_pc <= r_wr_ptr;
              r_wr_ptr  <= '0;
              r_loaded  <= 1'b1;
            end else begin
              r_wr_ptr  <= r_wr_ptr + 1'b1;
            end
          end else if (w_launch) begin
            r_rf[0]      <= launch_r0;
            r_pc         <= '0;
            r_err        <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            r_prog_ready <= 1'b0;
          end
        end
        ST_FETCH: r_ir <= r_imem[r_pc];
        ST_DEC: begin
          r_a <= r_rf[w_ra];
          r_b <= r_rf[w_rb];
          r_d <= r_rf[w_rd];
        end
        ST_EXEC: begin
          r_taken <= (w_op == OP_BNZ) && (r_a != '0);
          if (w_op == OP_LI)       r_res <= DATA_W'(r_ir[RA_HI:RB_LO]);
          else if (w_op == OP_NOP) r_res <= DATA_W'(core_id);
          else                     r_res <= w_alu_res;
          if (w_div0) r_err <= 1'b1;
        end
        ST_MEM: begin
          if (w_is_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_ST);
            r_mem_addr  <= w_addr;
            r_mem_wdata <= (w_op == OP_ST) ? r_d : '0;
          end
        end
        ST_MEMW: begin
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_res     <= mem.mem_rdata;
          end
        end
        ST_WB: begin
          if (writes_rd(r_ir)) r_rf[w_rd] <= r_res;
          if (r_taken) begin
            r_pc <= r_ir[PC_W-1:0];
          end else if (w_wb_end) begin
            r_pc         <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_prog_ready <= 1'b1;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_core_param.sv
// Directed self-checking bench for gpu_core_param with a delayed-ack memory responder.
// Latency: checks exact per-program cycle counts against hand-computed values.
// Backpressure: responder ack delay is programmable per scenario.
module tb_gpu_core_param;
  import gpu_core_pkg::*;

  localparam int DATA_W = 8, IMEM_DEPTH = 16, CORE_ID_W = 4, NCORES = 16, ADDR_W = 12;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [CORE_ID_W-1:0] core_id;
  logic                 prog_valid, prog_last, prog_ready;
  logic [15:0]          prog_data;
  logic                 launch_valid;
  logic [NCORES-1:0]    launch_mask;
  logic [DATA_W-1:0]    launch_r0;
  logic                 kill;
  logic                 ready, busy, err;

  gpu_core_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  gpu_core_param #(
    .DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .CORE_ID_W(CORE_ID_W),
    .NCORES(NCORES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .core_id(core_id),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
    .launch_valid(launch_valid), .launch_mask(launch_mask), .launch_r0(launch_r0),
    .kill(kill), .mem(mem_if), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder: acks after ack_delay extra cycles, logs each request.
  int          ack_delay = 4;
  logic [7:0]  rd_val = 8'h00;
  int          nreq = 0;
  int          cur_len = 0;
  int          req_len [16];
  logic [11:0] req_addr [16];
  logic        req_we [16];
  logic [7:0]  req_wdata [16];
  logic        req_stable [16];
  logic [11:0] cap_addr;
  logic        cap_we, cap_stable;
  logic [7:0]  cap_wdata;

  always @(negedge clk) begin
    if (mem_if.mem_req === 1'b1) begin
      if (cur_len == 0) begin
        cap_addr = mem_if.mem_addr; cap_we = mem_if.mem_we; cap_wdata = mem_if.mem_wdata; cap_stable = 1'b1;
      end else if (mem_if.mem_addr !== cap_addr || mem_if.mem_we !== cap_we || mem_if.mem_wdata !== cap_wdata) begin
        cap_stable = 1'b0;
      end
      cur_len++;
      if (cur_len == ack_delay + 1) begin
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = rd_val;
      end
    end else begin
      if (cur_len != 0 && nreq < 16) begin
        req_len[nreq] = cur_len; req_addr[nreq] = cap_addr; req_we[nreq] = cap_we;
        req_wdata[nreq] = cap_wdata; req_stable[nreq] = cap_stable;
        nreq++;
      end
      cur_len = 0;
      mem_if.mem_ack = 1'b0;
      mem_if.mem_rdata = 8'h00;
    end
  end

  logic [15:0] prog_buf [16];

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1; prog_data = prog_buf[i]; prog_last = (i == n - 1);
      @(negedge clk);
    end
    prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
  endtask

  task automatic do_launch(input logic [NCORES-1:0] mask, input logic [DATA_W-1:0] r0);
    launch_valid = 1'b1; launch_mask = mask; launch_r0 = r0;
    @(negedge clk);
    launch_valid = 1'b0; launch_mask = '0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (prog_ready !== 1'b1) begin n_bad++; $display("FAIL reset_prog_ready: got %b want 1", prog_ready); end
    n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
    n_cmp++; if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== 22'h0) begin
      n_bad++; $display("FAIL reset_mem: got %h want 0", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_noload();
    logic seen_busy;
    seen_busy = 1'b0;
    do_launch(16'h0008, 8'h11);
    repeat (4) begin seen_busy |= busy; @(negedge clk); end
    n_cmp++; if (seen_busy !== 1'b0) begin n_bad++; $display("FAIL noload_busy: got %b want 0", seen_busy); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL noload_ready: got %b want 1", ready); end
  endtask

  task automatic test_basic();
    int cyc;
    prog_buf[0] = 16'hC051; prog_buf[1] = 16'h1112; prog_buf[2] = 16'hF000;
    load_prog(3);
    do_launch(16'h0008, 8'h07);
    n_cmp++; if ({ready, busy, prog_ready} !== 3'b010) begin n_bad++; $display("FAIL basic_launch_flags: got %b want 010", {ready, busy, prog_ready}); end
    wait_ready(cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL basic_latency: got %0d want 15", cyc); end
    n_cmp++; if (dut.r_rf[2] !== 8'd10) begin n_bad++; $display("FAIL basic_r2: got %0d want 10", dut.r_rf[2]); end
    n_cmp++; if (dut.r_rf[0] !== 8'd7) begin n_bad++; $display("FAIL basic_r0: got %0d want 7", dut.r_rf[0]); end
    n_cmp++; if ({busy, prog_ready} !== 2'b01) begin n_bad++; $display("FAIL basic_done_flags: got %b want 01", {busy, prog_ready}); end
  endtask

  task automatic test_mask_clear();
    logic seen_busy;
    seen_busy = 1'b0;
    do_launch(16'hFFF7, 8'h33);
    repeat (6) begin seen_busy |= busy; @(negedge clk); end
    n_cmp++; if (seen_busy !== 1'b0) begin n_bad++; $display("FAIL mask_busy: got %b want 0", seen_busy); end
    n_cmp++; if (dut.r_rf[0] !== 8'd7) begin n_bad++; $display("FAIL mask_r0: got %h want 07", dut.r_rf[0]); end
  endtask

  task automatic test_mem();
    int cyc, b;
    ack_delay = 4; rd_val = 8'h5A; b = nreq;
    prog_buf[0] = 16'hCA53; prog_buf[1] = 16'hC014; prog_buf[2] = 16'hC235;
    prog_buf[3] = 16'hD453; prog_buf[4] = 16'hB456; prog_buf[5] = 16'hF000;
    load_prog(6);
    do_launch(16'h0008, 8'h00);
    wait_ready(cyc);
    @(negedge clk);
    n_cmp++; if (cyc !== 40) begin n_bad++; $display("FAIL mem_latency: got %0d want 40", cyc); end
    n_cmp++; if (nreq - b !== 2) begin n_bad++; $display("FAIL mem_nreq: got %0d want 2", nreq - b); end
    n_cmp++; if (req_len[b] !== 5) begin n_bad++; $display("FAIL st_req_len: got %0d want 5", req_len[b]); end
    n_cmp++; if (req_addr[b] !== 12'h123) begin n_bad++; $display("FAIL st_addr: got %h want 123", req_addr[b]); end
    n_cmp++; if (req_we[b] !== 1'b1) begin n_bad++; $display("FAIL st_we: got %b want 1", req_we[b]); end
    n_cmp++; if (req_wdata[b] !== 8'hA5) begin n_bad++; $display("FAIL st_wdata: got %h want a5", req_wdata[b]); end
    n_cmp++; if (req_stable[b] !== 1'b1) begin n_bad++; $display("FAIL st_stable: got %b want 1", req_stable[b]); end
    n_cmp++; if ({req_we[b+1], req_addr[b+1]} !== 13'h0123) begin n_bad++; $display("FAIL ld_we_addr: got %h want 0123", {req_we[b+1], req_addr[b+1]}); end
    n_cmp++; if (req_len[b+1] !== 5) begin n_bad++; $display("FAIL ld_req_len: got %0d want 5", req_len[b+1]); end
    n_cmp++; if (dut.r_rf[6] !== 8'h5A) begin n_bad++; $display("FAIL ld_r6: got %h want 5a", dut.r_rf[6]); end
  endtask

  task automatic test_loop();
    int cyc, ntr;
    logic [3:0] trace [16];
    logic [3:0] exp_pc [8];
    exp_pc = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3};
    prog_buf[0] = 16'hC031; prog_buf[1] = 16'h2101; prog_buf[2] = 16'hE101; prog_buf[3] = 16'hF000;
    load_prog(4);
    do_launch(16'h0008, 8'h01);
    cyc = 0; ntr = 0;
    if (dut.r_state == ST_FETCH) begin trace[ntr] = dut.r_pc; ntr++; end
    while (ready !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (dut.r_state == ST_FETCH && ntr < 16) begin trace[ntr] = dut.r_pc; ntr++; end
    end
    n_cmp++; if (cyc !== 40) begin n_bad++; $display("FAIL loop_latency: got %0d want 40", cyc); end
    n_cmp++; if (ntr !== 8) begin n_bad++; $display("FAIL loop_ninstr: got %0d want 8", ntr); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (trace[i] !== exp_pc[i]) begin n_bad++; $display("FAIL loop_pc[%0d]: got %0d want %0d", i, trace[i], exp_pc[i]); end
    end
    n_cmp++; if (dut.r_rf[1] !== 8'd0) begin n_bad++; $display("FAIL loop_count: got %0d want 0", dut.r_rf[1]); end
  endtask

  task automatic test_div0();
    int cyc;
    prog_buf[0] = 16'hC091; prog_buf[1] = 16'hC003; prog_buf[2] = 16'h4132; prog_buf[3] = 16'hF000;
    load_prog(4);
    do_launch(16'h0008, 8'h00);
    wait_ready(cyc);
    n_cmp++; if (dut.r_rf[2] !== 8'hFF) begin n_bad++; $display("FAIL div0_result: got %h want ff", dut.r_rf[2]); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL div0_err: got %b want 1", err); end
    prog_buf[1] = 16'hC033;
    load_prog(4);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL div0_err_sticky: got %b want 1", err); end
    do_launch(16'h0008, 8'h00);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL div0_err_cleared: got %b want 0", err); end
    wait_ready(cyc);
    n_cmp++; if (dut.r_rf[2] !== 8'd3) begin n_bad++; $display("FAIL div_result: got %h want 03", dut.r_rf[2]); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL div_err: got %b want 0", err); end
  endtask

  task automatic test_kill_reset();
    int cyc;
    logic seen_busy;
    ack_delay = 1000; rd_val = 8'h77;
    prog_buf[0] = 16'hC014; prog_buf[1] = 16'hC025; prog_buf[2] = 16'hC003;
    prog_buf[3] = 16'h4437; prog_buf[4] = 16'hB456; prog_buf[5] = 16'hF000;
    load_prog(6);
    do_launch(16'h0008, 8'h00);
    cyc = 0;
    while (dut.r_state != ST_MEMW && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_if.mem_req !== 1'b1) begin n_bad++; $display("FAIL kill_pre_req: got %b want 1", mem_if.mem_req); end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_cmp++; if ({mem_if.mem_req, mem_if.mem_we} !== 2'b00) begin n_bad++; $display("FAIL kill_req: got %b want 00", {mem_if.mem_req, mem_if.mem_we}); end
    n_cmp++; if ({ready, busy} !== 2'b10) begin n_bad++; $display("FAIL kill_flags: got %b want 10", {ready, busy}); end
    n_cmp++; if (dut.r_state !== ST_IDLE) begin n_bad++; $display("FAIL kill_state: got %0d want 0", dut.r_state); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL kill_err_kept: got %b want 1", err); end
    n_cmp++; if (dut.r_rf[6] !== 8'h5A) begin n_bad++; $display("FAIL kill_r6: got %h want 5a", dut.r_rf[6]); end
    prog_valid = 1'b1; prog_data = 16'h1234; prog_last = 1'b0;
    @(negedge clk);
    prog_data = 16'h5678;
    #2 reset_n = 1'b0; prog_valid = 1'b0;
    #1;
    n_cmp++; if ({ready, prog_ready, busy, err} !== 4'b1100) begin n_bad++; $display("FAIL rst_flags: got %b want 1100", {ready, prog_ready, busy, err}); end
    n_cmp++; if ({dut.r_loaded, dut.r_wr_ptr} !== 5'h00) begin n_bad++; $display("FAIL rst_loader: got %h want 00", {dut.r_loaded, dut.r_wr_ptr}); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    seen_busy = 1'b0;
    do_launch(16'h0008, 8'h00);
    repeat (3) begin seen_busy |= busy; @(negedge clk); end
    n_cmp++; if (seen_busy !== 1'b0) begin n_bad++; $display("FAIL rst_unloaded_launch: got %b want 0", seen_busy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    core_id = 4'd3; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
    launch_valid = 1'b0; launch_mask = '0; launch_r0 = '0; kill = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_noload();
    test_basic();
    test_mask_clear();
    test_mem();
    test_loop();
    test_div0();
    test_kill_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
